mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Data-memory responder: the slave end of the CPU memory stage's load/store interface. It replaces the single-cycle RAM path with a request/done handshake and a configurable access latency, which lets the memory stage be tested against a stalling memory. It accepts one request at a time, performs RV32I byte, half and word loads and stores (little-endian) on an internal word array, and pulses mem_done with the result.

Parameters:
ADDR_W, 8, word-address width; array depth is 2^ADDR_W 32-bit words.
LATENCY, 2, cycles from request acceptance to mem_done; legal range 1..15.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req  input  1  request valid; sampled only when busy=0
write_enable  input  1  1=store, 0=load; qualified by req
addr  input  32  byte address
wdata  input  32  store data; the low bytes are used for SB/SH
funct3  input  3  RV32I width/sign code
rdata  output  32  load result, sign/zero-extended; valid while mem_done=1
mem_done  output  1  one-cycle completion pulse
busy  output  1  request in flight; new req ignored
err  output  1  valid with mem_done; misaligned, out-of-range or illegal funct3

Behaviour:
- One clock and one reset. Reset is synchronous and active-high.
- Reset: state=IDLE, rdata=0, mem_done=0, busy=0, err=0, counter=0. Array contents are not cleared.
- States:
  - IDLE → (req) WAIT when LATENCY>1, else RESP.
  - WAIT → RESP when the counter reaches LATENCY-1.
  - RESP → IDLE unconditionally.
- Latency:
  - A request is accepted in cycle T (state IDLE, req=1). addr, wdata, write_enable and funct3 are latched then.
  - mem_done=1 exactly in cycle T+LATENCY.
  - busy=1 from cycle T+1 through cycle T+LATENCY.
  - The next acceptance is possible at T+LATENCY+1. Throughput is one access per LATENCY+1 cycles.
- req while busy=1 is ignored; it is not queued. A req held high across RESP is accepted again in the following IDLE cycle.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Error checks, evaluated on the latched request:
  - Misaligned: half with addr[0]=1, or word with addr[1:0]≠00.
  - Out of range: addr ≥ 4·2^ADDR_W.
  - Illegal funct3: any code not listed above.
- On error: no array write occurs; rdata=0 and err=1 with mem_done; the latency is unchanged.
- Stores:
  - The write commits at the RESP cycle edge.
  - Only the addressed byte lanes are written. SB writes lane addr[1:0]; SH writes lanes {addr[1],0} and {addr[1],1}.
- Loads:
  - The array word is read at RESP.
  - The selected lane(s) are shifted to bit 0 and extended: sign-extended for LB/LH, zero-extended for LBU/LHU.
  - rdata holds its value after mem_done falls until the next completion.
- A load to the same word as a just-completed store returns the new data (no forwarding needed; the commit precedes the read).
- Word index = addr[ADDR_W+1:2]. There is no wrap-around; out-of-range addresses are errors.
- Reset asserted mid-access aborts it: no write, no mem_done, and all state returns to reset values the next cycle.
- Outputs are registered; there is no combinational path from req to any output.

Decomposition:
- Shared package: FUNCT3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state encoding, and the mem_done/err response struct, reused by the memory stage.
- One natural sub-module: load_store_align. It is combinational and does two jobs:
  - Builds the byte-lane write mask and shifted write data from funct3, addr[1:0] and wdata.
  - Extracts and extends read data.
- mem_responder keeps the FSM, the counter and the array.

Test Plan:
1. LATENCY=2: SW addr 0x10, wdata 0xDEADBEEF at T → mem_done at T+2 with err=0. Then LW 0x10 → rdata 0xDEADBEEF.
2. SB 0x11, wdata 0x000000AA onto the word above → LW 0x10 = 0xDEADAABEF-free merge 0xDEADAAEF. LB 0x11 = 0xFFFFFFAA. LBU 0x11 = 0x000000AA.
3. SH 0x12 with 0x8001 → LH 0x12 = 0xFFFF8001, LHU 0x12 = 0x00008001. LW 0x13 → err=1, rdata=0, no write.
4. ADDR_W=8: SW 0x400 → err=1 and the array is unchanged; LW 0x3FC still returns its prior value.
5. req held high continuously at LATENCY=3 → mem_done every 4th cycle. busy=1 for 3 cycles after each acceptance; the extra reqs are ignored.
6. rst asserted one cycle after accepting SW 0x20 → no mem_done. LW 0x20 afterwards returns the old contents. Outputs are 0 the cycle after reset.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the data-memory responder and the memory stage that talks to it.
// Width codes, FSM encoding and the completion response bundle.
package mem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic mem_done;
        logic err;
    } mem_resp_t;

endpackage

// File: rtl/mem_responder_load_store_align.sv
// Byte-lane steering for RV32I loads and stores: write mask/data replication on the way in,
// lane extraction with sign or zero extension on the way out. Assumes alignment already checked.
module load_store_align
    import mem_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wmask,
    output logic [31:0] wshift,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    assign shifted = rword >> {byte_off, 3'b000};

    always_comb begin
        wmask  = 4'b0000;
        wshift = wdata;
        // Replicating the low bytes lets every lane see the store data; the mask picks the lane.
        case (funct3)
            F3_B: begin
                wmask  = 4'b0001 << byte_off;
                wshift = {4{wdata[7:0]}};
            end
            F3_H: begin
                wmask  = byte_off[1] ? 4'b1100 : 4'b0011;
                wshift = {2{wdata[15:0]}};
            end
            F3_W:    wmask = 4'b1111;
            default: wmask = 4'b0000;
        endcase
    end

    always_comb begin
        rdata = 32'd0;
        case (funct3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata = {24'd0, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata = {16'd0, shifted[15:0]};
            F3_W:    rdata = rword;
            default: rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Slave end of the memory-stage load/store interface: one request at a time, fixed
// LATENCY cycles from acceptance to the mem_done pulse, byte-lane word array behind it.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        write_enable,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        mem_done,
    output logic        busy,
    output logic        err
);

    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t      state_reg, state_next;
    logic [3:0]  count_reg, count_next;
    logic        lat_we_reg;
    logic [31:0] lat_addr_reg, lat_wdata_reg;
    logic [2:0]  lat_f3_reg;
    mem_resp_t   resp_reg;
    logic [31:0] rdata_reg;
    logic        busy_reg;

    // In IDLE the live inputs are the request (needed when LATENCY=1); afterwards the latched copy.
    logic              take_inputs;
    logic              cur_we;
    logic [31:0]       cur_addr, cur_wdata;
    logic [2:0]        cur_f3;
    logic [ADDR_W-1:0] idx;
    logic              f3_ok, misaligned, out_of_range, err_cur;
    logic [3:0]        wmask;
    logic [31:0]       wshift, rword, rd_ext;
    logic              do_write;

    assign take_inputs = (state_reg == ST_IDLE);
    assign cur_we      = take_inputs ? write_enable : lat_we_reg;
    assign cur_addr    = take_inputs ? addr : lat_addr_reg;
    assign cur_wdata   = take_inputs ? wdata : lat_wdata_reg;
    assign cur_f3      = take_inputs ? funct3 : lat_f3_reg;
    assign idx         = cur_addr[ADDR_W+1:2];

    assign f3_ok        = (cur_f3 == F3_B) || (cur_f3 == F3_H) || (cur_f3 == F3_W) ||
                          (!cur_we && ((cur_f3 == F3_BU) || (cur_f3 == F3_HU)));
    assign misaligned   = (((cur_f3 == F3_H) || (cur_f3 == F3_HU)) && cur_addr[0]) ||
                          ((cur_f3 == F3_W) && (cur_addr[1:0] != 2'b00));
    assign out_of_range = (cur_addr >> (ADDR_W + 2)) != 32'd0;
    assign err_cur      = !f3_ok || misaligned || out_of_range;

    load_store_align u_align (
        .funct3   (cur_f3),
        .byte_off (cur_addr[1:0]),
        .wdata    (cur_wdata),
        .rword    (rword),
        .wmask    (wmask),
        .wshift   (wshift),
        .rdata    (rd_ext)
    );

    // Commit happens on the edge that closes the RESP cycle, so a following load sees it.
    assign do_write = !rst && (state_reg == ST_RESP) && lat_we_reg && !resp_reg.err;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (do_write && wmask[gi]) begin
                    lane_mem[idx] <= wshift[8*gi +: 8];
                end
            end

            assign rword[8*gi +: 8] = lane_mem[idx];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            count_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    if (LATENCY > 1) begin
                        state_next = ST_WAIT;
                        count_next = 4'd1;
                    end else begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (count_reg == LAT_M1) begin
                    state_next = ST_RESP;
                    count_next = 4'd0;
                end else begin
                    count_next = count_reg + 4'd1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: begin
                state_next = ST_IDLE;
                count_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_reg == ST_IDLE && req) begin
            lat_we_reg    <= write_enable;
            lat_addr_reg  <= addr;
            lat_wdata_reg <= wdata;
            lat_f3_reg    <= funct3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_reg  <= '0;
            busy_reg  <= 1'b0;
            rdata_reg <= 32'd0;
        end else begin
            busy_reg          <= (state_next != ST_IDLE);
            resp_reg.mem_done <= (state_next == ST_RESP);
            resp_reg.err      <= (state_next == ST_RESP) && err_cur;
            if (state_next == ST_RESP) begin
                rdata_reg <= (err_cur || cur_we) ? 32'd0 : rd_ext;
            end
        end
    end

    assign rdata    = rdata_reg;
    assign mem_done = resp_reg.mem_done;
    assign err      = resp_reg.err;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized accesses
// checked against a byte-addressed reference memory.
module tb_mem_responder;

    localparam int LAT   = 2;
    localparam int LAT3  = 3;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst, req, write_enable;
    logic [31:0] addr, wdata;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        mem_done, busy, err;

    logic        req3;
    logic [31:0] rdata3;
    logic        mem_done3, busy3, err3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ref_mem [0:4*DEPTH-1];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .LATENCY(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .write_enable (write_enable),
        .addr         (addr),
        .wdata        (wdata),
        .funct3       (funct3),
        .rdata        (rdata),
        .mem_done     (mem_done),
        .busy         (busy),
        .err          (err)
    );

    mem_responder #(.ADDR_W(8), .LATENCY(LAT3)) dut3 (
        .clk          (clk),
        .rst          (rst),
        .req          (req3),
        .write_enable (1'b0),
        .addr         (32'h0000_0400),
        .wdata        (32'd0),
        .funct3       (3'b010),
        .rdata        (rdata3),
        .mem_done     (mem_done3),
        .busy         (busy3),
        .err          (err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: RV32I load/store semantics on a flat little-endian byte array.
    task automatic model(input logic we_i, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, output logic e, output logic [31:0] rd);
        int  sz;
        bit  sgn;
        bit  legal;
        int  base;
        logic [31:0] v;
        sz = 0; sgn = 0; legal = 1;
        case (f3)
            3'b000: begin sz = 1; sgn = 1; end
            3'b001: begin sz = 2; sgn = 1; end
            3'b010: begin sz = 4; sgn = 0; end
            3'b100: begin sz = 1; sgn = 0; legal = !we_i; end
            3'b101: begin sz = 2; sgn = 0; legal = !we_i; end
            default: legal = 0;
        endcase
        e  = !legal || (a % sz != 0) || (a >= 4 * DEPTH);
        rd = 32'd0;
        if (!e) begin
            base = int'(a);
            if (we_i) begin
                for (int i = 0; i < sz; i++) ref_mem[base + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[base + i];
                if (sgn && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
                rd = v;
            end
        end
    endtask

    task automatic access(input logic we_i, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] f3, input string tag, input bit given = 0,
                          input logic g_err = 1'b0, input logic [31:0] g_rd = 32'd0);
        logic        m_err;
        logic [31:0] m_rd;
        int          cyc;
        model(we_i, a, wd, f3, m_err, m_rd);
        if (given) begin
            m_err = g_err;
            m_rd  = g_rd;
        end
        @(negedge clk);
        req = 1'b1; write_enable = we_i; addr = a; wdata = wd; funct3 = f3;
        @(negedge clk);
        req = 1'b0; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom); write_enable = 1'($urandom);
        check({tag, ".busy_t1"}, {31'd0, busy}, 32'd1);
        cyc = 1;
        while (mem_done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ".latency"}, cyc, LAT);
        check({tag, ".err"}, {31'd0, err}, {31'd0, m_err});
        check({tag, ".busy_done"}, {31'd0, busy}, 32'd1);
        if (!we_i || m_err) check({tag, ".rdata"}, rdata, m_rd);
        $display("%s we=%0d addr=%h wdata=%h f3=%0d err=%0d rdata=%h", tag, we_i, a, wd, f3, err, rdata);
        @(negedge clk);
        check({tag, ".done_fall"}, {31'd0, mem_done}, 32'd0);
        check({tag, ".idle"}, {31'd0, busy}, 32'd0);
        if (!we_i) check({tag, ".rdata_hold"}, rdata, m_rd);
    endtask

    initial begin
        logic        old_err;
        logic [31:0] old_val;
        logic [31:0] ra;
        logic [2:0]  rf3;

        rst = 1'b1; req = 1'b0; req3 = 1'b0; write_enable = 1'b0;
        addr = 32'd0; wdata = 32'd0; funct3 = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset.rdata", rdata, 32'd0);
        check("reset.mem_done", {31'd0, mem_done}, 32'd0);
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.err", {31'd0, err}, 32'd0);
        check("reset.busy3", {31'd0, busy3}, 32'd0);

        for (int w = 0; w < 16; w++) access(1'b1, 32'(w * 4), $urandom, 3'b010, "init");
        access(1'b1, 32'h3FC, $urandom, 3'b010, "init");

        access(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, "t1_sw", 1, 1'b0);
        access(1'b0, 32'h10, 32'd0, 3'b010, "t1_lw", 1, 1'b0, 32'hDEADBEEF);

        access(1'b1, 32'h11, 32'h000000AA, 3'b000, "t2_sb", 1, 1'b0);
        access(1'b0, 32'h10, 32'd0, 3'b010, "t2_lw", 1, 1'b0, 32'hDEADAAEF);
        access(1'b0, 32'h11, 32'd0, 3'b000, "t2_lb", 1, 1'b0, 32'hFFFFFFAA);
        access(1'b0, 32'h11, 32'd0, 3'b100, "t2_lbu", 1, 1'b0, 32'h000000AA);

        access(1'b1, 32'h12, 32'h00008001, 3'b001, "t3_sh", 1, 1'b0);
        access(1'b0, 32'h12, 32'd0, 3'b001, "t3_lh", 1, 1'b0, 32'hFFFF8001);
        access(1'b0, 32'h12, 32'd0, 3'b101, "t3_lhu", 1, 1'b0, 32'h00008001);
        access(1'b0, 32'h13, 32'd0, 3'b010, "t3_lw_mis", 1, 1'b1, 32'd0);
        access(1'b1, 32'h13, 32'h11111111, 3'b010, "t3_sw_mis", 1, 1'b1, 32'd0);
        access(1'b0, 32'h10, 32'd0, 3'b010, "t3_lw_after", 1, 1'b0, 32'h8001AAEF);

        access(1'b1, 32'h400, 32'h12345678, 3'b010, "t4_sw_oor", 1, 1'b1, 32'd0);
        access(1'b0, 32'h3FC, 32'd0, 3'b010, "t4_lw_top");
        access(1'b0, 32'h000, 32'd0, 3'b010, "t4_lw_zero");

        // Abort an in-flight store with reset; memory must keep the old word.
        model(1'b0, 32'h20, 32'd0, 3'b010, old_err, old_val);
        @(negedge clk);
        req = 1'b1; write_enable = 1'b1; addr = 32'h20; wdata = ~old_val; funct3 = 3'b010;
        @(negedge clk);
        req = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6.rdata", rdata, 32'd0);
        check("t6.mem_done", {31'd0, mem_done}, 32'd0);
        check("t6.busy", {31'd0, busy}, 32'd0);
        check("t6.err", {31'd0, err}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t6.no_done", {31'd0, mem_done}, 32'd0);
        end
        $display("t6 reset abort of SW 0x20 wdata=%h", ~old_val);
        access(1'b0, 32'h20, 32'd0, 3'b010, "t6_lw", 1, 1'b0, old_val);

        for (int n = 0; n < 40; n++) begin
            ra  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) ra = 32'h3FC + 32'($urandom_range(0, 8));
            rf3 = 3'($urandom_range(0, 7));
            access(1'($urandom), ra, $urandom, rf3, "rand");
        end

        // Continuous req on the LATENCY=3 instance: completion every 4th cycle.
        @(negedge clk);
        req3 = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("t5.busy3", {31'd0, busy3}, {31'd0, (k % 4) != 0});
            check("t5.done3", {31'd0, mem_done3}, {31'd0, (k % 4) == 3});
            if ((k % 4) == 3) begin
                check("t5.err3", {31'd0, err3}, 32'd1);
                check("t5.rdata3", rdata3, 32'd0);
                $display("t5 cycle=%0d mem_done=%0d err=%0d", k, mem_done3, err3);
            end
        end
        req3 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
